// File: rtl/lfsr_arbiter.sv
// Round-robin controller that shares one 8-bit LFSR among NREQ requesters.
// Handles seeding, warm-up, and hands out one fresh random byte per grant.
module lfsr_arbiter #(
  parameter int          NREQ         = 4,
  parameter int          WARMUP       = 8,
  parameter logic [7:0]  SEED_DEFAULT = 8'hA5
) (
  input  logic            clock_i,
  input  logic            rst_ni,
  input  logic            seed_load_i,
  input  logic [7:0]      seed_i,
  input  logic [NREQ-1:0] req_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [7:0]      rnd_o,
  output logic            rnd_valid_o,
  output logic            busy_o
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {
    WARM,
    SERVE
  } state_e;

  localparam state_e ENTRY_STATE = (WARMUP == 0) ? SERVE : WARM;

  function automatic logic [7:0] lfsrStep(input logic [7:0] q);
    return {q[6:0], q[1] ^ q[2] ^ q[3] ^ q[7]};
  endfunction

  state_e          state_q, state_d;
  logic [7:0]      lfsr_q, lfsr_d;
  logic [7:0]      warmCnt_q, warmCnt_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [7:0]      rnd_q, rnd_d;
  logic            rndValid_q, rndValid_d;

  logic [NREQ-1:0] eligible;
  logic            found;
  logic [PW-1:0]   winner;
  logic [PW-1:0]   candIdx;

  // A requester granted last cycle is skipped so a held req is not counted twice.
  always_comb begin
    eligible = req_i & ~gnt_q;
    found    = 1'b0;
    winner   = '0;
    candIdx  = '0;
    for (int k = 1; k <= NREQ; k++) begin
      candIdx = PW'((int'(ptr_q) + k) % NREQ);
      if (!found && eligible[candIdx]) begin
        found  = 1'b1;
        winner = candIdx;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    lfsr_d     = lfsr_q;
    warmCnt_d  = warmCnt_q;
    ptr_d      = ptr_q;
    gnt_d      = '0;
    rnd_d      = rnd_q;
    rndValid_d = 1'b0;
    if (seed_load_i) begin
      lfsr_d    = (seed_i == 8'h00) ? 8'h01 : seed_i;
      warmCnt_d = 8'(WARMUP);
      state_d   = ENTRY_STATE;
    end else begin
      unique case (state_q)
        WARM: begin
          lfsr_d    = lfsrStep(lfsr_q);
          warmCnt_d = warmCnt_q - 8'd1;
          if (warmCnt_q <= 8'd1) state_d = SERVE;
        end
        SERVE: begin
          if (found) begin
            gnt_d[winner] = 1'b1;
            rnd_d         = lfsr_q;
            lfsr_d        = lfsrStep(lfsr_q);
            ptr_d         = winner;
            rndValid_d    = 1'b1;
          end
        end
        default: state_d = ENTRY_STATE;
      endcase
    end
  end

  always_ff @(posedge clock_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ENTRY_STATE;
      lfsr_q     <= SEED_DEFAULT;
      warmCnt_q  <= 8'(WARMUP);
      ptr_q      <= PW'(NREQ - 1);
      gnt_q      <= '0;
      rnd_q      <= 8'h00;
      rndValid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      lfsr_q     <= lfsr_d;
      warmCnt_q  <= warmCnt_d;
      ptr_q      <= ptr_d;
      gnt_q      <= gnt_d;
      rnd_q      <= rnd_d;
      rndValid_q <= rndValid_d;
    end
  end

  assign gnt_o       = gnt_q;
  assign rnd_o       = rnd_q;
  assign rnd_valid_o = rndValid_q;
  assign busy_o      = (state_q == WARM);

endmodule

// File: doc/lfsr_arbiter.md
# lfsr_arbiter

Round-robin controller that shares one 8-bit LFSR random source among `NREQ` requesters. It owns the LFSR state register, applies a seed on command, and runs a warm-up of discarded steps after every seed load. It then hands out one fresh pseudo-random byte per grant, advancing the LFSR only when a value is consumed. It sits between the shared LFSR datapath and the client blocks (game/test-pattern logic) that each need their own unrepeated random values.

## Interface
- `NREQ`, 4: number of requesters (2–8).
- `WARMUP`, 8: LFSR steps discarded after reset or seed load (0–255).
- `SEED_DEFAULT`, 8'hA5: LFSR value loaded by reset; must be nonzero.

- `clock`  in  1  single clock, all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `seed_load`  in  1  one-cycle strobe: load `seed` and restart warm-up.
- `seed`  in  8  seed value, sampled when `seed_load`=1.
- `req`  in  NREQ  level request per requester, one value per grant.
- `gnt`  out  NREQ  registered one-hot grant, one-cycle pulse.
- `rnd`  out  8  random byte delivered with `gnt`; holds last value otherwise.
- `rnd_valid`  out  1  high in exactly the cycles `gnt` is nonzero.
- `busy`  out  1  high while not in SERVE (seeding/warm-up).

## Operation
- LFSR step: `next = {q[6:0], q[1]^q[2]^q[3]^q[7]}`. This is the codebase LFSR polynomial.
- Zero-seed guard: a `seed` of 8'h00 loads 8'h01 instead, so all-zero lock-up cannot occur.
- FSM states: WARM, SERVE.
  - Reset: lfsr=`SEED_DEFAULT`, warm counter=`WARMUP`. State is WARM, or SERVE if `WARMUP`=0.
  - WARM: LFSR steps every cycle and the counter decrements. When the counter reaches 0, go to SERVE. No grants are issued in WARM.
  - SERVE: each cycle, if any eligible request exists, grant exactly one requester.
    - The granted requester receives the current lfsr value.
    - The LFSR steps once.
  - `seed_load`=1 in any state loads the guarded seed, sets counter=`WARMUP`, and enters WARM (or SERVE if `WARMUP`=0). No grant is issued in that cycle.
- Eligibility: `req[i]`=1 and `gnt[i]`=0 in the current cycle. A requester just granted is skipped for one cycle, so a held `req` is not double-counted.
- Round-robin: search starts at `ptr+1` and wraps at `NREQ-1`→0. After a grant to i, `ptr`=i. Reset `ptr`=`NREQ-1`, so requester 0 has first priority.
- The LFSR never steps in SERVE without a grant. Each delivered value is distinct and consecutive in the sequence.
- `busy` = (state==WARM).

## Timing
- Reset values: `gnt`=0, `rnd`=8'h00, `rnd_valid`=0, `busy`=1 (0 if `WARMUP`=0).
- Latency: `req` sampled at edge N produces `gnt`/`rnd`/`rnd_valid` valid after edge N+1. All outputs are registered.
- Throughput:
  - Aggregate: one value per cycle.
  - Single requester holding `req`: one value every 2 cycles.
- A requester wanting exactly one value deasserts `req` in the cycle it sees `gnt`.
- `seed_load` colliding with eligible requests: the seed wins, and `gnt`=0 and `rnd_valid`=0 the following cycle.
- Seed load during SERVE: warm-up restarts. Requests stall and remain pending; no request is lost.
- With `WARMUP`=W, the first grant is possible at the (W+1)th edge after the `seed_load` edge.
- `rst_n` deasserted mid-operation: all outputs clear immediately (asynchronous). Pending grants are dropped and `ptr` resets.
- `req` changes during WARM have no effect until SERVE.

## Test plan
- `WARMUP`=2, `seed_load` with `seed`=8'hA5, then `req`=4'b0001 held → `busy` high 2 cycles; first `rnd`=8'h94 with `gnt`=0001; next grant (2 cycles later) `rnd`=8'h28, then 8'h51, 8'hA2.
- `WARMUP`=0, seed 8'hA5, `req`=4'b1111 held → `gnt` sequence 0001,0010,0100,1000,0001 on consecutive cycles; `rnd`=A5,4A,94,28,51; `rnd_valid` continuously high.
- `seed`=8'h00 load, `WARMUP`=0, one request → `rnd`=8'h01, then 8'h02 on the next grant; the LFSR never sticks at 0.
- `req`=4'b1010 held, `seed_load` pulsed in SERVE → `gnt`=0 the next cycle; `busy` high `WARMUP` cycles; grants resume with the requester after the last granted one; no LFSR step is lost or duplicated relative to the new seed.
- `rst_n` pulsed low while `gnt` is high → `gnt`/`rnd_valid`/`rnd` go to 0 asynchronously; after release the sequence restarts from `SEED_DEFAULT` and requester 0 is granted first.
- No requests in SERVE for 20 cycles, then one request → `rnd` equals the value held before the idle period (no steps during idle).
